// File: rtl/fanout_fork_ctrl.sv
// ----------------------------------------------------------------------------
// fanout_fork_ctrl
//
// Eager-fork controller: broadcasts one producer token to up to NUM_OUT
// destinations. Each destination accepts the token exactly once. The producer
// is released (in_ready) only when every active destination has taken it.
//
// The active destination set is cfg_enable & cfg_sel while idle. It is
// snapshotted when a token goes partial, so configuration changes made
// mid-token only take effect for the next token.
//
// Ports
//   clk         clock
//   rst_n       synchronous active-low reset
//   clk_en      global clock enable; 0 freezes all state and blanks handshakes
//   flush       synchronous flush of the in-flight fork state (tok_count kept)
//   cfg_enable  per-destination configuration enable
//   cfg_sel     per-destination stream select
//   in_data     producer token
//   in_valid    producer valid
//   in_ready    token fully delivered; producer may advance
//   out_data    broadcast token (equal to in_data)
//   out_valid   per-destination valid
//   out_ready   per-destination ready
//   busy        fork partially delivered
//   tok_count   completed tokens, saturating at 32'hFFFF_FFFF
//   stall_count (FANOUT_FORK_STALL_CNT_EN only) one 16-bit saturating
//               counter per destination, counting valid-but-not-ready cycles
//
// Optional feature macro: FANOUT_FORK_STALL_CNT_EN
// ----------------------------------------------------------------------------
module fanout_fork_ctrl #(
    parameter int NUM_OUT = 9,
    parameter int DATA_W  = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic [NUM_OUT-1:0]    cfg_enable,
    input  logic [NUM_OUT-1:0]    cfg_sel,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic                  busy,
    output logic [31:0]           tok_count
`ifdef FANOUT_FORK_STALL_CNT_EN
    ,
    output logic [NUM_OUT*16-1:0] stall_count
`endif
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PARTIAL = 1'b1;

    logic [0:0]         r_state;
    logic [NUM_OUT-1:0] r_sent;
    logic [NUM_OUT-1:0] r_mask;
    logic [31:0]        r_tok;

    logic [NUM_OUT-1:0] w_act;
    logic [NUM_OUT-1:0] w_pend;
    logic [NUM_OUT-1:0] w_fire;
    logic               w_done;
    logic               w_gate;
    logic [31:0]        w_tok_inc;

    // Handshakes are blanked in reset, during flush and while the clock is
    // disabled, so no destination can observe a transfer that is not recorded.
    assign w_gate    = clk_en & rst_n & ~flush;

    assign w_act     = (r_state == S_PARTIAL) ? r_mask : (cfg_enable & cfg_sel);
    assign w_pend    = w_act & ~r_sent;
    // A destination is satisfied if inactive, already served, or taking it now.
    assign w_done    = &(~w_act | r_sent | out_ready);

    assign out_valid = {NUM_OUT{in_valid & w_gate}} & w_pend;
    assign w_fire    = out_valid & out_ready;
    assign in_ready  = w_done & in_valid & w_gate;
    assign out_data  = in_data;
    assign busy      = (r_state == S_PARTIAL);
    assign tok_count = r_tok;

    assign w_tok_inc = (r_tok == 32'hFFFF_FFFF) ? r_tok : (r_tok + 32'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sent  <= '0;
            r_mask  <= '0;
            r_tok   <= '0;
        end else if (clk_en) begin
            if (flush) begin
                r_state <= S_IDLE;
                r_sent  <= '0;
                r_mask  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (in_valid) begin
                            if (w_done) begin
                                r_tok <= w_tok_inc;
                            end else begin
                                r_sent  <= w_fire;
                                r_mask  <= w_act;
                                r_state <= S_PARTIAL;
                            end
                        end
                    end
                    default: begin
                        // A producer that drops valid mid-token stalls the
                        // fork: nothing fires and the token cannot complete.
                        if (in_valid) begin
                            if (w_done) begin
                                r_sent  <= '0;
                                r_mask  <= '0;
                                r_tok   <= w_tok_inc;
                                r_state <= S_IDLE;
                            end else begin
                                r_sent <= r_sent | w_fire;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef FANOUT_FORK_STALL_CNT_EN
    logic [NUM_OUT-1:0][15:0] r_stall;

    // out_valid already carries clk_en and flush gating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                if (out_valid[i] && !out_ready[i] && (r_stall[i] != 16'hFFFF)) begin
                    r_stall[i] <= r_stall[i] + 16'd1;
                end
            end
        end
    end

    assign stall_count = r_stall;
`endif

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fanout_fork_ctrl
//
// Scoreboard bench for fanout_fork_ctrl (NUM_OUT=9, DATA_W=17). The driver
// applies one cycle of stimulus, computes the expected outputs from a
// set-based model of the fork (which destinations still owe the current
// token), and pushes them to a queue. A separate monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_fanout_fork_ctrl;

    localparam int N  = 9;
    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  cfg_enable = '0;
    logic [N-1:0]  cfg_sel = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready = '0;
    logic          busy;
    logic [31:0]   tok_count;
`ifdef FANOUT_FORK_STALL_CNT_EN
    logic [N*16-1:0] stall_count;
`endif

    fanout_fork_ctrl #(.NUM_OUT(N), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .flush      (flush),
        .cfg_enable (cfg_enable),
        .cfg_sel    (cfg_sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .tok_count  (tok_count)
`ifdef FANOUT_FORK_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  ov;
        logic          ir;
        logic          bsy;
        logic [31:0]   tok;
        logic [DW-1:0] data;
        int            stall [N];
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   tb_done  = 1'b0;

    // Reference state: is a token part-delivered, which destinations it
    // targets, which have already taken it, and the statistics.
    bit           m_open = 1'b0;
    logic [N-1:0] m_target = '0;
    logic [N-1:0] m_taken = '0;
    logic [31:0]  m_tok = '0;
    int           m_stall [N];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input bit fl,
                       input logic [N-1:0] ce, input logic [N-1:0] cs,
                       input logic [DW-1:0] d, input bit v, input logic [N-1:0] rdy);
        exp_t         e;
        logic [N-1:0] targets;
        logic [N-1:0] owed;
        bit           all_take;
        bit           live;
        @(negedge clk);
        rst_n = rst; clk_en = en; flush = fl;
        cfg_enable = ce; cfg_sel = cs; in_data = d; in_valid = v; out_ready = rdy;
        #1;
        targets  = m_open ? m_target : (ce & cs);
        owed     = targets & ~m_taken;
        all_take = ((owed & ~rdy) == '0);
        live     = rst && en && !fl;
        e.ov   = (live && v) ? owed : '0;
        e.ir   = live && v && all_take;
        e.bsy  = m_open;
        e.tok  = m_tok;
        e.data = d;
        foreach (m_stall[i]) e.stall[i] = m_stall[i];
        q.push_back(e);

        if (!rst) begin
            m_open = 1'b0; m_target = '0; m_taken = '0; m_tok = '0;
            foreach (m_stall[i]) m_stall[i] = 0;
        end else if (en) begin
            for (int i = 0; i < N; i++)
                if (e.ov[i] && !rdy[i] && m_stall[i] < 65535) m_stall[i]++;
            if (fl) begin
                m_open = 1'b0; m_taken = '0;
            end else if (v) begin
                if (all_take) begin
                    if (m_tok != 32'hFFFF_FFFF) m_tok = m_tok + 32'd1;
                    m_open = 1'b0; m_taken = '0;
                end else begin
                    m_open = 1'b1; m_target = targets; m_taken = m_taken | (owed & rdy);
                end
            end
        end
    endtask

    // Monitor: compares every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        while (!tb_done) begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out_valid", 32'(out_valid), 32'(e.ov));
                check("in_ready", 32'(in_ready), 32'(e.ir));
                check("busy", 32'(busy), 32'(e.bsy));
                check("tok_count", tok_count, e.tok);
                check("out_data", 32'(out_data), 32'(e.data));
`ifdef FANOUT_FORK_STALL_CNT_EN
                for (int i = 0; i < N; i++)
                    check($sformatf("stall_count[%0d]", i),
                          32'(stall_count[i*16 +: 16]), 32'(e.stall[i]));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] rce, rcs;
        foreach (m_stall[i]) m_stall[i] = 0;
        // Reset held from time 0; first compared cycle is still in reset.
        cyc(0, 1, 0, '1, '1, 17'h0, 1, '1);
        cyc(0, 1, 0, '1, '1, 17'h0, 0, '0);

        // All nine destinations ready: single-cycle completion.
        cyc(1, 1, 0, 9'h1FF, 9'h1FF, 17'h00A5, 1, 9'h1FF);
        cyc(1, 1, 0, 9'h1FF, 9'h1FF, 17'h0000, 0, 9'h000);

        // Split delivery 0x03 then 0x0C.
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h0111, 1, 9'h003);
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h0111, 1, 9'h00C);
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h0000, 0, 9'h000);

        // Config change mid-token is ignored until completion.
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h0222, 1, 9'h001);
        cyc(1, 1, 0, 9'h1FF, 9'h1F0, 17'h0222, 1, 9'h1F2);
        cyc(1, 1, 0, 9'h1FF, 9'h1F0, 17'h0222, 1, 9'h00C);
        cyc(1, 1, 0, 9'h1FF, 9'h1F0, 17'h0333, 1, 9'h000);
        cyc(1, 1, 0, 9'h1FF, 9'h1F0, 17'h0333, 1, 9'h1F0);

        // No active destinations: sink for five tokens.
        for (int k = 0; k < 5; k++)
            cyc(1, 1, 0, 9'h1FF, 9'h000, 17'(k), 1, 9'h000);

        // Flush mid-token, then the re-presented token is offered to all again.
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h1444, 1, 9'h001);
        cyc(1, 1, 1, 9'h1FF, 9'h00F, 17'h1444, 1, 9'h002);
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h1444, 1, 9'h000);
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h1444, 1, 9'h00F);

        // Clock disabled mid-token, destination 2 stalls over active cycles.
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h0555, 1, 9'h000);
        for (int k = 0; k < 3; k++)
            cyc(1, 0, 0, 9'h1FF, 9'h00F, 17'h0555, 1, 9'h000);
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h0555, 1, 9'h00B);
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h0555, 1, 9'h000);
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h0555, 1, 9'h000);
        cyc(1, 1, 0, 9'h1FF, 9'h00F, 17'h0555, 1, 9'h004);

        // Randomized traffic.
        rce = 9'h1FF; rcs = 9'h0FF;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                rce = N'($urandom);
                rcs = N'($urandom);
            end
            cyc($urandom_range(0, 299) != 0,
                $urandom_range(0, 9) != 0,
                $urandom_range(0, 29) == 0,
                rce, rcs, DW'($urandom),
                $urandom_range(0, 6) != 0,
                N'($urandom));
        end
        cyc(1, 1, 0, rce, rcs, '0, 0, '0);

        @(negedge clk);
        #4;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        tb_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
